// File: rtl/bcd_score_counter.sv
// -----------------------------------------------------------------------------
// bcd_score_counter
//   Multi-digit packed-BCD up/down score counter.  Counts increment/decrement
//   events with decimal carry/borrow across all digits, supports wrap-around or
//   saturating behaviour at both ends, synchronous clear and clamped load.
//
// Parameters
//   DIGITS  number of BCD digits (1..8), digit 0 least significant
//   WRAP    1: wrap around at 9..9 / 0..0, 0: saturate at both ends
//   EDGE    1: count rising edges of inc/dec, 0: count every cycle high
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous, active-high reset
//   inc       in   add one point
//   dec       in   subtract one point
//   clear     in   synchronous clear to zero (highest priority)
//   load      in   synchronous load of load_val (digits > 9 clamped to 9)
//   load_val  in   packed BCD load value, digit d at [4d+3:4d]
//   score     out  packed BCD score, digit d at [4d+3:4d]
//   at_max    out  score is all nines
//   at_min    out  score is zero
//   wrapped   out  one-cycle pulse: wrap occurred or saturation blocked a step
//   hiscore   out  highest score seen since reset (only with SCORE_HISCORE_EN)
//
// Configuration macro
//   SCORE_HISCORE_EN  adds the hiscore output and its register
// -----------------------------------------------------------------------------
module bcd_score_counter #(
   parameter int DIGITS = 4,
   parameter int WRAP   = 0,
   parameter int EDGE   = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  inc,
   input  logic                  dec,
   input  logic                  clear,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   score,
   output logic                  at_max,
   output logic                  at_min,
   output logic                  wrapped
`ifdef SCORE_HISCORE_EN
  ,output logic [4*DIGITS-1:0]   hiscore
`endif
);

   localparam int W = 4 * DIGITS;

   // Decimal +1 with the carry rippling through every digit in one cycle.
   function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         c;
      r = v;
      c = 1'b1;
      for (int d = 0; d < DIGITS; d++) begin
         if (c) begin
            if (r[4*d +: 4] >= 4'd9) begin
               r[4*d +: 4] = 4'd0;
            end else begin
               r[4*d +: 4] = r[4*d +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Decimal -1 with the borrow rippling through every digit in one cycle.
   function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         b;
      r = v;
      b = 1'b1;
      for (int d = 0; d < DIGITS; d++) begin
         if (b) begin
            if (r[4*d +: 4] == 4'd0) begin
               r[4*d +: 4] = 4'd9;
            end else begin
               r[4*d +: 4] = r[4*d +: 4] - 4'd1;
               b = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Saturate each loaded digit into the legal BCD range.
   function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
      logic [W-1:0] r;
      for (int d = 0; d < DIGITS; d++) begin
         r[4*d +: 4] = (v[4*d +: 4] > 4'd9) ? 4'd9 : v[4*d +: 4];
      end
      return r;
   endfunction

   function automatic logic bcd_all_nines(input logic [W-1:0] v);
      logic r;
      r = 1'b1;
      for (int d = 0; d < DIGITS; d++) begin
         if (v[4*d +: 4] != 4'd9) r = 1'b0;
      end
      return r;
   endfunction

   logic         inc_q, dec_q;
   logic         inc_ev, dec_ev;
   logic [W-1:0] score_n;
   logic         wrapped_n;

   // Event detection: rising edge or level, chosen at elaboration.
   always_comb begin
      if (EDGE != 0) begin
         inc_ev = inc & ~inc_q;
         dec_ev = dec & ~dec_q;
      end else begin
         inc_ev = inc;
         dec_ev = dec;
      end
   end

   // Next score: clear > load > count; simultaneous inc/dec cancel out.
   always_comb begin
      score_n   = score;
      wrapped_n = 1'b0;
      if (clear) begin
         score_n = '0;
      end else if (load) begin
         score_n = bcd_clamp(load_val);
      end else if (inc_ev && !dec_ev) begin
         if (bcd_all_nines(score)) begin
            wrapped_n = 1'b1;
            score_n   = (WRAP != 0) ? '0 : score;
         end else begin
            score_n = bcd_inc(score);
         end
      end else if (dec_ev && !inc_ev) begin
         if (score == '0) begin
            wrapped_n = 1'b1;
            score_n   = (WRAP != 0) ? {DIGITS{4'd9}} : score;
         end else begin
            score_n = bcd_dec(score);
         end
      end
   end

   // Register stage: flags are computed from score_n so they align with score.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         score   <= '0;
         at_max  <= 1'b0;
         at_min  <= 1'b1;
         wrapped <= 1'b0;
         inc_q   <= 1'b0;
         dec_q   <= 1'b0;
      end else begin
         score   <= score_n;
         at_max  <= bcd_all_nines(score_n);
         at_min  <= (score_n == '0);
         wrapped <= wrapped_n;
         inc_q   <= inc;
         dec_q   <= dec;
      end
   end

`ifdef SCORE_HISCORE_EN
   // Both operands are always valid BCD, so plain binary ordering of the packed
   // vectors equals decimal magnitude ordering.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hiscore <= '0;
      end else if (score_n > hiscore) begin
         hiscore <= score_n;
      end
   end
`endif

endmodule

// File: tb/tb_bcd_score_counter.sv
module tb_bcd_score_counter;

   localparam int D    = 4;
   localparam int W    = 4 * D;
   localparam int MAXV = 9999;
   localparam int N    = 3;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic inc = 1'b0, dec = 1'b0, clear = 1'b0, load = 1'b0;
   logic [W-1:0] load_val = '0;

   logic [W-1:0] sc0, sc1, sc2;
   logic mx0, mx1, mx2, mn0, mn1, mn2, wr0, wr1, wr2;
   logic [W-1:0] hi0, hi1, hi2;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   // u0: saturate/edge, u1: wrap/edge, u2: wrap/level
   bcd_score_counter #(.DIGITS(D), .WRAP(0), .EDGE(1)) u0 (
      .clk(clk), .reset(reset), .inc(inc), .dec(dec), .clear(clear), .load(load),
      .load_val(load_val), .score(sc0), .at_max(mx0), .at_min(mn0), .wrapped(wr0)
`ifdef SCORE_HISCORE_EN
     ,.hiscore(hi0)
`endif
   );
   bcd_score_counter #(.DIGITS(D), .WRAP(1), .EDGE(1)) u1 (
      .clk(clk), .reset(reset), .inc(inc), .dec(dec), .clear(clear), .load(load),
      .load_val(load_val), .score(sc1), .at_max(mx1), .at_min(mn1), .wrapped(wr1)
`ifdef SCORE_HISCORE_EN
     ,.hiscore(hi1)
`endif
   );
   bcd_score_counter #(.DIGITS(D), .WRAP(1), .EDGE(0)) u2 (
      .clk(clk), .reset(reset), .inc(inc), .dec(dec), .clear(clear), .load(load),
      .load_val(load_val), .score(sc2), .at_max(mx2), .at_min(mn2), .wrapped(wr2)
`ifdef SCORE_HISCORE_EN
     ,.hiscore(hi2)
`endif
   );

`ifndef SCORE_HISCORE_EN
   assign hi0 = '0;
   assign hi1 = '0;
   assign hi2 = '0;
`endif

   // ---------------- reference model (integer arithmetic) ----------------
   int val  [N];
   int hival[N];
   bit pinc [N];
   bit pdec [N];

   typedef struct packed {
      logic [N-1:0][W-1:0] sc;
      logic [N-1:0][W-1:0] hi;
      logic [N-1:0]        mx;
      logic [N-1:0]        mn;
      logic [N-1:0]        wr;
   } exp_t;

   exp_t sbq[$];

   function automatic logic [W-1:0] to_bcd(input int v);
      logic [W-1:0] r;
      int t;
      t = v;
      for (int d = 0; d < D; d++) begin
         r[4*d +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic int clamp_to_int(input logic [W-1:0] lv);
      int r, p, nib;
      r = 0;
      p = 1;
      for (int d = 0; d < D; d++) begin
         nib = int'(lv[4*d +: 4]);
         if (nib > 9) nib = 9;
         r = r + nib * p;
         p = p * 10;
      end
      return r;
   endfunction

   function automatic exp_t snapshot(input bit [N-1:0] wr);
      exp_t e;
      for (int k = 0; k < N; k++) begin
         e.sc[k] = to_bcd(val[k]);
         e.hi[k] = to_bcd(hival[k]);
         e.mx[k] = (val[k] == MAXV);
         e.mn[k] = (val[k] == 0);
         e.wr[k] = wr[k];
      end
      return e;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < N; k++) begin
         val[k] = 0; hival[k] = 0; pinc[k] = 0; pdec[k] = 0;
      end
   endtask

   // ---------------- driver ----------------
   task automatic rst_cycle(input bit hold_inc);
      @(negedge clk);
      reset = 1'b1;
      inc = hold_inc; dec = 1'b0; clear = 1'b0; load = 1'b0;
      model_reset();
      sbq.push_back(snapshot('0));
   endtask

   task automatic step(input bit i_, input bit d_, input bit c_, input bit l_,
                       input logic [W-1:0] lv);
      bit [N-1:0] wr;
      bit ie, de, wrap_m, edge_m;
      @(negedge clk);
      reset = 1'b0;
      inc = i_; dec = d_; clear = c_; load = l_; load_val = lv;
      wr = '0;
      for (int k = 0; k < N; k++) begin
         wrap_m = (k != 0);
         edge_m = (k != 2);
         ie = edge_m ? (i_ && !pinc[k]) : i_;
         de = edge_m ? (d_ && !pdec[k]) : d_;
         pinc[k] = i_;
         pdec[k] = d_;
         if (c_) val[k] = 0;
         else if (l_) val[k] = clamp_to_int(lv);
         else if (ie && !de) begin
            if (val[k] == MAXV) begin
               wr[k] = 1'b1;
               if (wrap_m) val[k] = 0;
            end else val[k] = val[k] + 1;
         end else if (de && !ie) begin
            if (val[k] == 0) begin
               wr[k] = 1'b1;
               if (wrap_m) val[k] = MAXV;
            end else val[k] = val[k] - 1;
         end
         if (val[k] > hival[k]) hival[k] = val[k];
      end
      sbq.push_back(snapshot(wr));
   endtask

   task automatic idle();
      step(0, 0, 0, 0, '0);
   endtask

   task automatic pulses_inc(input int n);
      for (int i = 0; i < n; i++) begin
         step(1, 0, 0, 0, '0);
         idle();
      end
   endtask

   // ---------------- checker ----------------
   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   task automatic chk_unit(input int k, input exp_t e, input logic [W-1:0] s,
                           input logic m, input logic n, input logic w,
                           input logic [W-1:0] h);
      chk($sformatf("u%0d.score", k), s, e.sc[k]);
      chk($sformatf("u%0d.at_max", k), W'(m), W'(e.mx[k]));
      chk($sformatf("u%0d.at_min", k), W'(n), W'(e.mn[k]));
      chk($sformatf("u%0d.wrapped", k), W'(w), W'(e.wr[k]));
`ifdef SCORE_HISCORE_EN
      chk($sformatf("u%0d.hiscore", k), h, e.hi[k]);
`else
      if (h !== h) chk("hiscore_unused", h, e.hi[k]);
`endif
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         chk_unit(0, e, sc0, mx0, mn0, wr0, hi0);
         chk_unit(1, e, sc1, mx1, mn1, wr1, hi1);
         chk_unit(2, e, sc2, mx2, mn2, wr2, hi2);
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [W-1:0] lv;
      int r;
      rst_cycle(0);
      rst_cycle(0);

      pulses_inc(12);                              // 0012
      step(0, 0, 0, 1, 16'h0100);                  // borrow across two digits
      step(0, 1, 0, 0, '0); idle();
      step(1, 0, 0, 0, '0); idle();

      step(0, 0, 0, 1, 16'h9999);                  // top boundary
      step(1, 0, 0, 0, '0); idle(); idle();
      step(0, 1, 0, 0, '0); idle();
      step(0, 0, 0, 1, 16'h0000);                  // bottom boundary
      step(0, 1, 0, 0, '0); idle();

      step(0, 0, 0, 1, 16'h0345);
      step(1, 1, 0, 0, '0); idle();                // inc+dec cancel
      step(1, 0, 1, 0, '0); idle();                // clear wins over inc
      step(0, 0, 0, 1, 16'hA3F5); idle();          // clamp to 9395
      step(1, 0, 1, 1, 16'h1234); idle();          // clear wins over load

      for (int i = 0; i < 10; i++) step(1, 0, 0, 0, '0);   // held inc
      idle();

      step(0, 0, 1, 0, '0);
      pulses_inc(42);
      step(0, 0, 1, 0, '0);
      pulses_inc(7);

      // asynchronous reset between clocks
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      chk("async.score0", sc0, '0);
      chk("async.score1", sc1, '0);
      chk("async.score2", sc2, '0);
      chk("async.at_min0", W'(mn0), W'(1));
`ifdef SCORE_HISCORE_EN
      chk("async.hiscore0", hi0, '0);
      chk("async.hiscore2", hi2, '0);
`endif
      rst_cycle(1);                                // inc high as reset releases
      step(1, 0, 0, 0, '0); idle();

      for (int i = 0; i < 600; i++) begin
         r = $urandom_range(0, 99);
         case ($urandom_range(0, 4))
            0: lv = 16'h9999;
            1: lv = 16'h0000;
            2: lv = 16'h9998;
            3: lv = 16'h0001;
            default: lv = W'($urandom);
         endcase
         step(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
              (r < 3), (r >= 3 && r < 9), lv);
      end
      idle();
      repeat (2) @(negedge clk);

      n_cmp++;
      if (sbq.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain actual=%0d required=0", sbq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
